// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared types, constants and helpers for the sequence generator
package seq_gen_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_GRAY = 2'd2,
    MODE_LFSR = 2'd3
  } seq_mode_e;

  // LFSR restarts here after lockup; reaching it again marks a new period
  localparam int unsigned LFSR_SEED = 1;

  // Maximal-length Fibonacci tap masks (bit n-1 is always a tap) for widths 3..16
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] taps;
    case (width)
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h000C;
    endcase
    return taps;
  endfunction

  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/seq_gen_step.sv
// rtl/seq_gen_step.sv - combinational next-state and wrap computation for one sequence step
module seq_gen_step
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] state_i,
  input  seq_mode_e        mode_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED      = WIDTH'(LFSR_SEED);

  logic [WIDTH-1:0] lfsr_shift;
  assign lfsr_shift = {state_i[WIDTH-2:0], ^(state_i & TAPS)};

  // Bounded counting for UP/GRAY/DOWN; lo>hi simply pins at the restart bound
  always_comb begin
    next_o = state_i;
    wrap_o = 1'b0;
    case (mode_i)
      MODE_UP, MODE_GRAY: begin
        if (state_i >= hi_i) begin
          next_o = lo_i;
          wrap_o = 1'b1;
        end else begin
          next_o = state_i + WIDTH'(1);
        end
      end
      MODE_DOWN: begin
        if (state_i <= lo_i) begin
          next_o = hi_i;
          wrap_o = 1'b1;
        end else begin
          next_o = state_i - WIDTH'(1);
        end
      end
      MODE_LFSR: begin
        if (state_i == '0) begin
          next_o = SEED;
        end else begin
          next_o = lfsr_shift;
          wrap_o = (lfsr_shift == SEED);
        end
      end
      default: begin
        next_o = state_i;
        wrap_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_gen_multi.sv
// rtl/seq_gen_multi.sv - multi-mode bounded sequence generator with wrap pulse and period counter
module seq_gen_multi
  import seq_gen_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic [CNT_W-1:0] period_cnt
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] step_next;
  logic             step_wrap;
  seq_mode_e        mode_e;

  assign mode_e = seq_mode_e'(mode);

  // Output encoding is chosen by the mode on the edge that updates state
  function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] v, input seq_mode_e m);
    logic [15:0] g;
    g = bin2gray(16'(v));
    return (m == MODE_GRAY) ? g[WIDTH-1:0] : v;
  endfunction

  seq_gen_step #(.WIDTH(WIDTH)) u_step (
    .state_i (state_q),
    .mode_i  (mode_e),
    .lo_i    (lo),
    .hi_i    (hi),
    .next_o  (step_next),
    .wrap_o  (step_wrap)
  );

  // Load beats enable; hold keeps everything except the wrap pulse
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = load_val;
      out_d   = encode(load_val, mode_e);
      cnt_d   = '0;
    end else if (en) begin
      state_d = step_next;
      out_d   = encode(step_next, mode_e);
      wrap_d  = step_wrap;
      if (step_wrap && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State, output and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_VAL;
      out_q   <= RESET_VAL;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out        = out_q;
  assign wrap       = wrap_q;
  assign period_cnt = cnt_q;

endmodule

// File: tb/tb_seq_gen_multi.sv
// tb/tb_seq_gen_multi.sv - self-checking bench for seq_gen_multi
module tb_seq_gen_multi;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] lo = '0;
  logic [W-1:0] hi = '0;
  logic [W-1:0] out1, out2;
  logic         wrap1, wrap2;
  logic [7:0]   pc1;
  logic [1:0]   pc2;

  int checks = 0;
  int errors = 0;

  seq_gen_multi #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .lo(lo), .hi(hi), .out(out1), .wrap(wrap1), .period_cnt(pc1)
  );

  seq_gen_multi #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .lo(lo), .hi(hi), .out(out2), .wrap(wrap2), .period_cnt(pc2)
  );

  // Reference model: the maximal 4-bit LFSR cycle listed as a plain table
  int lfsr_seq[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
  int m_state = 0, m_out = 0, m_wrap = 0, m_cnt = 0, m_cnt2 = 0;
  bit m_valid = 1'b0;

  function automatic int enc(input int v, input int m);
    return (m == 2) ? (v ^ (v >> 1)) : v;
  endfunction

  function automatic void ref_step(input int s, input int m, input int l, input int h,
                                   output int nx, output int w);
    nx = s;
    w  = 0;
    if (m == 0 || m == 2) begin
      if (s >= h) begin nx = l; w = 1; end else nx = s + 1;
    end else if (m == 1) begin
      if (s <= l) begin nx = h; w = 1; end else nx = s - 1;
    end else begin
      if (s == 0) nx = 1;
      else begin
        for (int i = 0; i < 15; i++)
          if (lfsr_seq[i] == s) nx = lfsr_seq[(i + 1) % 15];
        w = (nx == 1) ? 1 : 0;
      end
    end
  endfunction

  always @(posedge clk) begin
    int nx, w;
    if (!rst_n) begin
      m_state <= 0; m_out <= 0; m_wrap <= 0; m_cnt <= 0; m_cnt2 <= 0;
    end else if (load) begin
      m_state <= int'(load_val); m_out <= enc(int'(load_val), int'(mode));
      m_wrap <= 0; m_cnt <= 0; m_cnt2 <= 0;
    end else if (en) begin
      ref_step(m_state, int'(mode), int'(lo), int'(hi), nx, w);
      m_state <= nx;
      m_out   <= enc(nx, int'(mode));
      m_wrap  <= w;
      if (w == 1) begin
        m_cnt  <= (m_cnt  < 255) ? m_cnt + 1  : 255;
        m_cnt2 <= (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
      end
    end else begin
      m_wrap <= 0;
    end
    m_valid <= 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("out", int'(out1), m_out);
      check("wrap", int'(wrap1), m_wrap);
      check("period_cnt", int'(pc1), m_cnt);
      check("sat_out", int'(out2), m_out);
      check("sat_period_cnt", int'(pc2), m_cnt2);
    end
  end

  task automatic step(input bit r, input bit e, input bit ld, input int md,
                      input int lv, input int l, input int h);
    rst_n = r; en = e; load = ld; mode = 2'(md);
    load_val = W'(lv); lo = W'(l); hi = W'(h);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string name, input int o, input int w, input int pc);
    check({name, "_out"}, int'(out1), o);
    check({name, "_wrap"}, int'(wrap1), w);
    check({name, "_pc"}, int'(pc1), pc);
    check({name, "_model_out"}, m_out, o);
  endtask

  int up_exp[11]   = '{1, 2, 3, 4, 5, 6, 3, 4, 5, 6, 3};
  int gray_exp[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
  int lfsr_exp[16] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
  int down_exp[4]  = '{3, 2, 5, 4};

  initial begin
    step(0, 1, 1, 0, 9, 0, 15);
    step(0, 0, 0, 0, 0, 0, 15);
    expect_lit("reset", 0, 0, 0);

    for (int i = 0; i < 11; i++) begin
      step(1, 1, 0, 0, 0, 3, 6);
      expect_lit("up", up_exp[i], (i == 6 || i == 10) ? 1 : 0, (i < 6) ? 0 : (i < 10) ? 1 : 2);
    end
    step(0, 1, 0, 0, 0, 3, 6);
    expect_lit("mid_reset", 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, 2, 0, 0, 15);
      expect_lit("gray", gray_exp[i], (i == 15) ? 1 : 0, (i == 15) ? 1 : 0);
    end

    step(0, 0, 0, 3, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, 3, 0, 0, 0);
      expect_lit("lfsr", lfsr_exp[i], (i == 15) ? 1 : 0, (i == 15) ? 1 : 0);
    end

    step(1, 1, 1, 1, 4, 2, 5);
    expect_lit("down_load", 4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 1, 0, 2, 5);
      expect_lit("down", down_exp[i], (i == 2) ? 1 : 0, (i >= 2) ? 1 : 0);
    end

    step(1, 0, 1, 0, 4, 3, 6);
    step(1, 1, 0, 0, 0, 3, 6);
    expect_lit("pre_hold", 5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 3, 6);
      expect_lit("hold", 5, 0, 0);
    end
    step(1, 1, 0, 0, 0, 3, 6);
    expect_lit("resume", 6, 0, 0);

    step(1, 0, 1, 0, 6, 0, 15);
    step(1, 0, 0, 2, 0, 0, 15);
    expect_lit("hold_mode_change", 6, 0, 0);
    step(1, 1, 0, 2, 0, 0, 15);
    expect_lit("gray_after_hold", 4, 0, 0);

    step(1, 0, 1, 0, 5, 7, 3);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0, 0, 7, 3);
      expect_lit("up_inverted", 7, 1, i + 1);
      check("sat_cnt", int'(pc2), (i + 1 < 3) ? i + 1 : 3);
    end
    step(1, 0, 1, 1, 1, 7, 3);
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 1, 0, 7, 3);
      expect_lit("down_inverted", 3, 1, i + 1);
    end

    for (int n = 0; n < 3000; n++) begin
      int lv, l, h, md;
      bit r, e, ld;
      r  = ($urandom_range(0, 99) != 0);
      ld = ($urandom_range(0, 15) == 0);
      e  = ($urandom_range(0, 3) != 0);
      md = (n % 200 < 40) ? 3 : int'($urandom_range(0, 3));
      lv = int'($urandom_range(0, 15));
      l  = int'($urandom_range(0, 15));
      h  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(l, 15));
      step(r, e, ld, md, lv, l, h);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_gen_multi.md
Name: seq_gen_multi

Overview:
- Parametrised successor to the fixed 4-bit sequence generator.
- Produces a WIDTH-bit sequence in one of four runtime-selectable modes: up-count, down-count, Gray-coded up-count, maximal-length LFSR.
- Adds programmable lo/hi bounds, enable, parallel load, a wrap pulse and a saturating period counter.
- Used as a stimulus/pattern source and as a pacing counter feeding downstream datapath blocks.

Parameters:
- WIDTH, 4, sequence width in bits; legal range 3..16.
- CNT_W, 8, width of the period counter.
- RESET_VAL, 0, internal state value after reset.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  advance the sequence one step on this edge.
- mode  in  2  0=UP, 1=DOWN, 2=GRAY, 3=LFSR.
- load  in  1  parallel load request.
- load_val  in  WIDTH  value loaded into internal state.
- lo  in  WIDTH  lower bound; UP/DOWN/GRAY only.
- hi  in  WIDTH  upper bound; UP/DOWN/GRAY only.
- out  out  WIDTH  registered encoded sequence value.
- wrap  out  1  one-cycle pulse, coincident with out showing the first value of a new period.
- period_cnt  out  CNT_W  completed periods; saturates at 2^CNT_W-1.

Behaviour:
- Internal binary register state[WIDTH-1:0]. out is registered and always equals encode(state): Gray mode = state^(state>>1); all other modes = state. Zero added latency between state and out.
- Reset (rst_n=0 at a clk edge): state=RESET_VAL, out=RESET_VAL, wrap=0, period_cnt=0. rst_n overrides load and en. Reset mid-sequence abandons the sequence; no wrap is emitted.
- Priority per edge: reset > load > en > hold.
- Load: state=load_val, out=encode(load_val) under the current mode, wrap=0, period_cnt=0. load_val is not clamped to lo/hi.
- Hold (en=0, load=0): state, out and period_cnt keep their values; wrap=0.
- UP and GRAY: if state>=hi, next=lo and wrap=1; else next=state+1.
- DOWN: if state<=lo, next=hi and wrap=1; else next=state-1.
- If lo>hi: UP/GRAY sit at lo with wrap=1 on every enabled edge; DOWN sits at hi the same way. Deterministic and legal; no error flag.
- LFSR: Fibonacci, shift left, new bit0 = XOR of the tap bits from the package table for WIDTH. Bounds are ignored.
- LFSR wrap=1 when next==LFSR_SEED (1).
- LFSR lockup: if state==0 on an enabled edge, next=LFSR_SEED with wrap=0.
- mode is sampled every enabled edge. A mode change takes effect immediately from the current state; no flush and no wrap is generated by the change itself.
- out encoding follows the mode on the edge where state updates. A mode change during hold does not alter out until the next update.
- period_cnt increments on every edge where wrap is set. It holds at all-ones when saturated.
- Simultaneous load and en: load wins and en is ignored for that edge.

Decomposition:
- Package seq_gen_pkg holds:
  - mode enum type (UP, DOWN, GRAY, LFSR);
  - LFSR_SEED constant;
  - function lfsr_taps(width), returning a maximal-length tap mask for widths 3..16 (e.g. width 4 returns taps bit3^bit2);
  - function bin2gray.
- One sub-module is natural: seq_gen_step. It is purely combinational: takes state, mode, lo and hi; returns next state and the wrap flag. The top module holds the registers, priority logic and period counter.

Test Plan:
- Reset then UP, lo=3, hi=6, en=1 from state 0 -> out 1,2,3,4,5,6,3,4,5,6,3; wrap high when out first returns to 3 and every 4 cycles after; period_cnt increments 1,2.
- GRAY, lo=0, hi=15, from reset -> out 1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; wrap with the 0.
- LFSR WIDTH=4 from state 0 -> 1 (no wrap), then 2,4,9,3,6,D,A,5,B,7,F,E,C,8,1 (wrap); repeats with period 15.
- DOWN, lo=2, hi=5, load_val=4 asserted together with en -> out 4 on that edge (load wins), then 3,2,5(wrap),4; period_cnt cleared by the load, then 1 after the wrap.
- Toggle en low for 3 cycles mid-UP sequence at out=5 -> out holds 5 with wrap=0; resumes at 6 on the next en. Separately, lo=7, hi=3 in UP -> out=7 with wrap on every enabled edge.
- Drive rst_n low for one edge mid-sequence at period_cnt=2 -> out=0 and period_cnt=0 on the next edge. Separately, with CNT_W=2, run 5 UP wraps -> period_cnt saturates at 3.
